// File: rtl/intel_vvp_bayer_pkg.sv
// Shared types and constants for the Bayer white-balance block.
package intel_vvp_bayer_pkg;

    typedef enum logic [1:0] {
        CFA_B     = 2'b00,
        CFA_G     = 2'b01,
        CFA_R     = 2'b10,
        CFA_UNITY = 2'b11
    } cfa_code_e;

    localparam int GAIN_W = 16;
    localparam int FRAC_W = 12;
    localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h1000;

    // Lane width: sample padded to at least 8 bits, rounded up to whole bytes.
    function automatic int padded_lane_w(input int bps);
        int p;
        p = (bps > 8) ? bps : 8;
        return ((p + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/intel_vvp_bayer_wbal_lane.sv
// One Bayer lane: subtract black, multiply by 4.12 gain, round and clip.
module intel_vvp_bayer_wbal_lane
    import intel_vvp_bayer_pkg::*;
#(
    parameter int BPS    = 10,
    parameter int LANE_W = 16
) (
    input  logic              main_clock,
    input  logic              main_reset,
    input  logic              en,
    input  logic [BPS-1:0]    pix,
    input  logic [BPS-1:0]    black,
    input  logic [GAIN_W-1:0] gain,
    output logic [LANE_W-1:0] pix_out,
    output logic              clip
);

    localparam int PROD_W = BPS + GAIN_W;
    localparam int Y_W    = PROD_W + 1 - FRAC_W;
    localparam logic [PROD_W:0] ROUND = (PROD_W+1)'(2 ** (FRAC_W - 1));

    logic [BPS-1:0]    d_s1;
    logic [GAIN_W-1:0] gain_s1;
    logic [PROD_W-1:0] prod_s2;
    logic [PROD_W:0]   sum;
    logic [Y_W-1:0]    y;
    logic              clip_c;
    logic [BPS-1:0]    y_sat;

    assign sum    = {1'b0, prod_s2} + ROUND;
    assign y      = sum[PROD_W:FRAC_W];
    assign clip_c = |y[Y_W-1:BPS];
    assign y_sat  = clip_c ? {BPS{1'b1}} : y[BPS-1:0];

    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            d_s1    <= '0;
            gain_s1 <= '0;
            prod_s2 <= '0;
            pix_out <= '0;
            clip    <= 1'b0;
        end else if (en) begin
            d_s1    <= (pix > black) ? pix - black : '0;
            gain_s1 <= gain;
            prod_s2 <= PROD_W'(d_s1) * PROD_W'(gain_s1);
            pix_out <= LANE_W'(y_sat);
            clip    <= clip_c;
        end
    end

endmodule

// File: rtl/intel_vvp_bayer_wbal.sv
// Bayer white balance over AXI4-Stream: per-site gain and black level, 3-cycle pipeline.
// Optional clipped-pixel counter enabled by INTEL_VVP_BAYER_WBAL_CLIP_CNT_EN.
module intel_vvp_bayer_wbal
    import intel_vvp_bayer_pkg::*;
#(
    parameter int         PIXELS_IN_PARALLEL = 2,
    parameter int         BPS                = 10,
    parameter logic [7:0] C_CFA_MODE         = 8'b00010110,
    localparam int        C_PADDED_BPS       = (BPS > 8) ? BPS : 8,
    localparam int        LANE_W             = padded_lane_w(BPS),
    localparam int        TDATA_W            = PIXELS_IN_PARALLEL * LANE_W,
    localparam int        TUSER_W            = TDATA_W / 8
) (
    input  logic               main_clock,
    input  logic               main_reset,
    input  logic [TDATA_W-1:0] axi4s_vid_in_tdata,
    input  logic               axi4s_vid_in_tlast,
    input  logic [TUSER_W-1:0] axi4s_vid_in_tuser,
    input  logic               axi4s_vid_in_tvalid,
    output logic               axi4s_vid_in_tready,
    output logic [TDATA_W-1:0] axi4s_vid_out_tdata,
    output logic               axi4s_vid_out_tlast,
    output logic [TUSER_W-1:0] axi4s_vid_out_tuser,
    output logic               axi4s_vid_out_tvalid,
    input  logic               axi4s_vid_out_tready,
    input  logic [7:0]         r_vid_cfa_mode,
    input  logic [GAIN_W-1:0]  r_gain_b,
    input  logic [GAIN_W-1:0]  r_gain_g,
    input  logic [GAIN_W-1:0]  r_gain_r,
    input  logic [BPS-1:0]     r_black_level
`ifdef INTEL_VVP_BAYER_WBAL_CLIP_CNT_EN
    ,
    output logic [31:0]        clip_count
`endif
);

    localparam int PIP = PIXELS_IN_PARALLEL;

    logic en, acc, sof_in;
    logic [3:1] vld_pipe, last_pipe, sof_pipe;

    assign en                  = ~axi4s_vid_out_tvalid | axi4s_vid_out_tready;
    assign axi4s_vid_in_tready = en;
    assign acc                 = axi4s_vid_in_tvalid & en;
    assign sof_in              = axi4s_vid_in_tuser[0];

    // Frame-latched settings; a SOF beat uses the live values directly.
    logic [7:0]        cfa_q, cfa_e;
    logic [GAIN_W-1:0] gb_q, gg_q, gr_q, gb_e, gg_e, gr_e;
    logic [BPS-1:0]    blk_q, blk_e;

    assign cfa_e = sof_in ? r_vid_cfa_mode : cfa_q;
    assign gb_e  = sof_in ? r_gain_b       : gb_q;
    assign gg_e  = sof_in ? r_gain_g       : gg_q;
    assign gr_e  = sof_in ? r_gain_r       : gr_q;
    assign blk_e = sof_in ? r_black_level  : blk_q;

    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            cfa_q <= C_CFA_MODE;
            gb_q  <= UNITY_GAIN;
            gg_q  <= UNITY_GAIN;
            gr_q  <= UNITY_GAIN;
            blk_q <= '0;
        end else if (acc && sof_in) begin
            cfa_q <= r_vid_cfa_mode;
            gb_q  <= r_gain_b;
            gg_q  <= r_gain_g;
            gr_q  <= r_gain_r;
            blk_q <= r_black_level;
        end
    end

    logic line_par, eff_line;
    logic [PIP-1:0] col_par;

    assign eff_line = ~sof_in & line_par;

    always_ff @(posedge main_clock) begin
        if (main_reset)
            line_par <= 1'b0;
        else if (acc)
            line_par <= eff_line ^ axi4s_vid_in_tlast;
    end

    generate
        if (PIP == 1) begin : g_col_beat
            logic col_q, eff_col;
            assign eff_col    = ~sof_in & col_q;
            assign col_par[0] = eff_col;
            always_ff @(posedge main_clock) begin
                if (main_reset)
                    col_q <= 1'b0;
                else if (acc)
                    col_q <= axi4s_vid_in_tlast ? 1'b0 : ~eff_col;
            end
        end else begin : g_col_lane
            for (genvar i = 0; i < PIP; i++) begin : g_par
                assign col_par[i] = 1'(i % 2);
            end
        end
    endgenerate

    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            sof_pipe  <= '0;
        end else if (en) begin
            vld_pipe  <= {vld_pipe[2:1],  axi4s_vid_in_tvalid};
            last_pipe <= {last_pipe[2:1], axi4s_vid_in_tlast};
            sof_pipe  <= {sof_pipe[2:1],  sof_in};
        end
    end

    logic [PIP-1:0][LANE_W-1:0] pix_o;
    logic [PIP-1:0]             clip_o;

    generate
        for (genvar i = 0; i < PIP; i++) begin : g_lane
            cfa_code_e         code;
            logic [GAIN_W-1:0] gain;

            // Line 0 uses map bits [7:4], line 1 bits [3:0]; odd columns take the upper pair.
            assign code = cfa_code_e'(cfa_e[{~eff_line, col_par[i], 1'b0} +: 2]);

            always_comb begin
                case (code)
                    CFA_B:   gain = gb_e;
                    CFA_G:   gain = gg_e;
                    CFA_R:   gain = gr_e;
                    default: gain = UNITY_GAIN;
                endcase
            end

            intel_vvp_bayer_wbal_lane #(
                .BPS    (BPS),
                .LANE_W (LANE_W)
            ) u_lane (
                .main_clock (main_clock),
                .main_reset (main_reset),
                .en         (en),
                .pix        (axi4s_vid_in_tdata[i*LANE_W +: BPS]),
                .black      (blk_e),
                .gain       (gain),
                .pix_out    (pix_o[i]),
                .clip       (clip_o[i])
            );
        end
    endgenerate

    assign axi4s_vid_out_tdata  = pix_o;
    assign axi4s_vid_out_tvalid = vld_pipe[3];
    assign axi4s_vid_out_tlast  = last_pipe[3];
    assign axi4s_vid_out_tuser  = TUSER_W'(sof_pipe[3]);

    logic unused_in;
    assign unused_in = ^{axi4s_vid_in_tdata, axi4s_vid_in_tuser, C_PADDED_BPS[0]};

`ifdef INTEL_VVP_BAYER_WBAL_CLIP_CNT_EN
    logic [31:0] clip_cur, beat_clips;
    logic [32:0] clip_sum;

    always_comb begin
        beat_clips = '0;
        for (int i = 0; i < PIP; i++)
            beat_clips = beat_clips + 32'(clip_o[i]);
    end

    assign clip_sum = {1'b0, clip_cur} + {1'b0, beat_clips};

    // Count accumulates over output beats; published and restarted at each output SOF.
    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            clip_cur   <= '0;
            clip_count <= '0;
        end else if (axi4s_vid_out_tvalid && axi4s_vid_out_tready) begin
            if (sof_pipe[3]) begin
                clip_count <= clip_cur;
                clip_cur   <= beat_clips;
            end else begin
                clip_cur   <= clip_sum[32] ? 32'hFFFF_FFFF : clip_sum[31:0];
            end
        end
    end
`else
    logic unused_clip;
    assign unused_clip = ^clip_o;
`endif

endmodule

// File: tb/tb_intel_vvp_bayer_wbal.sv
// Scoreboard bench: randomized Bayer frames checked against an arithmetic reference model.
module tb_intel_vvp_bayer_wbal;

    localparam int PIP     = 2;
    localparam int BPS     = 10;
    localparam int LANE_W  = 16;
    localparam int TDATA_W = PIP * LANE_W;
    localparam int TUSER_W = TDATA_W / 8;
    localparam int MAXV    = (1 << BPS) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [TDATA_W-1:0] in_tdata;
    logic               in_tlast;
    logic [TUSER_W-1:0] in_tuser;
    logic               in_tvalid;
    logic               in_tready;
    logic [TDATA_W-1:0] out_tdata;
    logic               out_tlast;
    logic [TUSER_W-1:0] out_tuser;
    logic               out_tvalid;
    logic               out_tready;
    logic [7:0]         r_map;
    logic [15:0]        r_gb, r_gg, r_gr;
    logic [BPS-1:0]     r_blk;
`ifdef INTEL_VVP_BAYER_WBAL_CLIP_CNT_EN
    logic [31:0]        clip_count;
`endif

    intel_vvp_bayer_wbal #(.PIXELS_IN_PARALLEL(PIP), .BPS(BPS)) dut (
        .main_clock           (clk),
        .main_reset           (rst),
        .axi4s_vid_in_tdata   (in_tdata),
        .axi4s_vid_in_tlast   (in_tlast),
        .axi4s_vid_in_tuser   (in_tuser),
        .axi4s_vid_in_tvalid  (in_tvalid),
        .axi4s_vid_in_tready  (in_tready),
        .axi4s_vid_out_tdata  (out_tdata),
        .axi4s_vid_out_tlast  (out_tlast),
        .axi4s_vid_out_tuser  (out_tuser),
        .axi4s_vid_out_tvalid (out_tvalid),
        .axi4s_vid_out_tready (out_tready),
        .r_vid_cfa_mode       (r_map),
        .r_gain_b             (r_gb),
        .r_gain_g             (r_gg),
        .r_gain_r             (r_gr),
        .r_black_level        (r_blk)
`ifdef INTEL_VVP_BAYER_WBAL_CLIP_CNT_EN
        ,
        .clip_count           (clip_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TDATA_W-1:0] data;
        logic               last;
        logic               sof;
        int                 cyc;
        bit                 lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   tready_mode = 0;   // 0 always ready, 1 random, 2 stalled
    bit   lat_tag = 0;

    // Reference model state: settings captured at SOF, current line index.
    logic [7:0] m_map;
    int         m_gain[3];
    int         m_blk, m_line;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_map = 8'h16;
        for (int k = 0; k < 3; k++) m_gain[k] = 4096;
        m_blk = 0;
        m_line = 0;
    endtask

    task automatic model_accept(input int pix[PIP], input bit sof, input bit last);
        exp_t e;
        logic [1:0] code;
        int g, d, y;
        if (sof) begin
            m_map = r_map;
            m_gain[0] = int'(r_gb); m_gain[1] = int'(r_gg); m_gain[2] = int'(r_gr);
            m_blk = int'(r_blk);
            m_line = 0;
        end
        e.data = '0;
        for (int i = 0; i < PIP; i++) begin
            if (m_line % 2 == 0) code = (i % 2 == 0) ? m_map[5:4] : m_map[7:6];
            else                 code = (i % 2 == 0) ? m_map[1:0] : m_map[3:2];
            g = (code == 2'b11) ? 4096 : m_gain[code];
            d = pix[i] - m_blk;
            if (d < 0) d = 0;
            y = (d * g + 2048) / 4096;
            if (y > MAXV) y = MAXV;
            e.data[i*LANE_W +: LANE_W] = LANE_W'(y);
        end
        e.last = last; e.sof = sof; e.cyc = cyc; e.lat = lat_tag;
        sbq.push_back(e);
        if (last) m_line++;
    endtask

    task automatic send_beat(input int pix[PIP], input bit sof, input bit last);
        bit ok = 0;
        for (int i = 0; i < PIP; i++) in_tdata[i*LANE_W +: LANE_W] = LANE_W'(pix[i]);
        in_tuser  = TUSER_W'({$urandom_range(0, 7), sof});
        in_tlast  = last;
        in_tvalid = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (in_tready === 1'b1) begin
                model_accept(pix, sof, last);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int lines, input int beats, input bit gaps, input int chg_line);
        int px[PIP];
        for (int l = 0; l < lines; l++)
            for (int b = 0; b < beats; b++) begin
                if (l == chg_line && b == 0) r_gg = 16'($urandom_range(0, 16'h3fff));
                foreach (px[i]) px[i] = $urandom_range(0, MAXV);
                send_beat(px, l == 0 && b == 0, b == beats - 1);
                if (gaps && $urandom_range(0, 3) == 0) begin
                    in_tvalid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        in_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        in_tvalid = 1'b0;
        while (sbq.size() != 0 && t < 500) begin
            @(posedge clk); t++;
        end
        #1;
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    always begin
        @(posedge clk); #1;
        case (tready_mode)
            0:       out_tready = 1'b1;
            2:       out_tready = 1'b0;
            default: out_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops and compares every transferred output beat, checks hold while stalled.
    logic [TDATA_W-1:0] h_data;
    logic               h_last;
    logic [TUSER_W-1:0] h_user;
    bit                 held = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 0;
        end else begin
            if (held)
                chk("hold_stable", 64'({out_tvalid, out_tlast, out_tuser, out_tdata}),
                    64'({1'b1, h_last, h_user, h_data}));
            if (out_tvalid && !out_tready)
                chk("in_tready_stall", 64'(in_tready), 64'd0);
            if (out_tvalid && out_tready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("tdata", 64'(out_tdata), 64'(e.data));
                    chk("tlast", 64'(out_tlast), 64'(e.last));
                    chk("tuser", 64'(out_tuser), 64'(TUSER_W'(e.sof)));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
                end
            end
            held = out_tvalid && !out_tready;
            h_data = out_tdata; h_last = out_tlast; h_user = out_tuser;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int px[PIP];
        rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; in_tuser = '0;
        out_tready = 1'b1;
        r_map = 8'h16; r_gb = 16'h1000; r_gg = 16'h1000; r_gr = 16'h1000; r_blk = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_tdata",  64'(out_tdata),  64'd0);
        chk("rst_tlast",  64'(out_tlast),  64'd0);
        chk("rst_tuser",  64'(out_tuser),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Unity passthrough with latency tag.
        lat_tag = 1;
        px = '{32'h155, 32'h155};
        send_beat(px, 1, 1);
        lat_tag = 0;
        drain();

        // Black level and clip on R sites of line 1.
        r_blk = 10'd64; r_gr = 16'h2000;
        px = '{100, 100}; send_beat(px, 1, 1);
        px = '{600, 300}; send_beat(px, 0, 0);
        px = '{40, 300};  send_beat(px, 0, 1);
        drain();

        // CFA phasing over two lines.
        r_blk = '0; r_gb = 16'h0800; r_gg = 16'h1000; r_gr = 16'h2000;
        px = '{200, 200};
        send_beat(px, 1, 0); send_beat(px, 0, 1);
        send_beat(px, 0, 0); send_beat(px, 0, 1);
        drain();

        // Backpressure: 5 stalled cycles mid-line.
        fork
            send_frame(1, 12, 0, -1);
            begin
                repeat (6) @(posedge clk);
                tready_mode = 2;
                repeat (5) @(posedge clk);
                tready_mode = 0;
            end
        join
        drain();

        // Mid-frame gain change, then a frame that picks it up.
        send_frame(4, 3, 0, 2);
        send_frame(2, 3, 0, -1);
        drain();

        // Mid-line reset; then non-SOF beats see defaults, then a fresh frame.
        r_map = 8'hE4; r_gb = 16'h0c00; r_gg = 16'h1400; r_gr = 16'h0900; r_blk = 10'd20;
        px = '{500, 500};
        send_beat(px, 1, 0); send_beat(px, 0, 0); send_beat(px, 0, 0);
        in_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        model_reset();
        @(negedge clk);
        chk("post_rst_tvalid", 64'(out_tvalid), 64'd0);
        @(posedge clk); #1;
        px = '{300, 700}; send_beat(px, 0, 0);
        px = '{900, 50};  send_beat(px, 0, 1);
        px = '{900, 50};  send_beat(px, 0, 1);
        send_frame(3, 2, 0, -1);
        drain();

        // Randomized frames with random backpressure, gaps and mid-frame changes.
        tready_mode = 1;
        for (int f = 0; f < 8; f++) begin
            r_map = 8'($urandom_range(0, 255));
            r_gb  = 16'($urandom_range(0, 16'h3fff));
            r_gg  = 16'($urandom_range(0, 16'h3fff));
            r_gr  = 16'($urandom_range(0, 16'h3fff));
            r_blk = BPS'($urandom_range(0, 127));
            send_frame($urandom_range(1, 4), $urandom_range(1, 5), 1, $urandom_range(0, 3));
        end
        drain();
        tready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/intel_vvp_bayer_wbal.md
INTEL_VVP_BAYER_WBAL -- requirements
Module: intel_vvp_bayer_wbal

Interface
REQ-001 SHALL have parameter PIXELS_IN_PARALLEL, default 2, giving the Bayer pixels per beat.
REQ-002 SHALL have parameter BPS, default 10, giving bits per sample; the padded width is C_PADDED_BPS = max(BPS,8), and each lane is rounded up to whole bytes.
REQ-003 SHALL have parameter C_CFA_MODE, default 8'b00010110, which is the reset CFA map; codes are 00=B, 01=G, 10=R, 11=unity gain.
REQ-004 SHALL have port main_clock, input, 1 bit: the single clock.
REQ-005 SHALL have port main_reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have ports axi4s_vid_in_tdata/tlast/tuser/tvalid (inputs) and tready (output), where tdata is PIXELS_IN_PARALLEL byte-rounded lanes and tuser is tdata width/8; this is the Bayer input stream.
REQ-007 SHALL have ports axi4s_vid_out_tdata/tlast/tuser/tvalid (outputs) and tready (input), with widths identical to the input stream.
REQ-008 SHALL have port r_vid_cfa_mode, input, 8 bits: the CPU CFA map.
REQ-009 SHALL have ports r_gain_b, r_gain_g and r_gain_r, input, 16 bits each: unsigned 4.12 gains, where 0x1000 = 1.0.
REQ-010 SHALL have port r_black_level, input, BPS bits: the black offset subtracted before gain.

Function
REQ-011 SHALL latch all r_* inputs on the accepted beat with tuser[0]=1 (SOF), and SHALL apply the new values to that SOF beat itself and to the rest of the frame.
REQ-012 SHALL track a line parity that is cleared at SOF and toggles on each accepted tlast.
- For PIXELS_IN_PARALLEL>1, the column parity of a lane is its lane index modulo 2.
- For PIXELS_IN_PARALLEL=1, the column parity toggles per accepted beat and clears on tlast.
REQ-013 SHALL select the CFA code as follows:
- first line of frame (parity 0): [5:4] for even columns, [7:6] for odd columns;
- parity 1: [1:0] for even columns, [3:2] for odd columns.
REQ-014 SHALL compute per lane: d = max(in − black, 0); y = (d·gain + 0x800) >> 12; out = min(y, 2^BPS − 1). Code 11 SHALL use gain 0x1000. Padding bits SHALL be zero.
REQ-015 SHALL implement a 3-stage pipeline (subtract, multiply, round/clip), giving a fixed latency of 3 cycles from accepted input to presented output when unstalled.
REQ-016 SHALL carry tlast and tuser[0] through the pipeline aligned with their data, and SHALL drive output tuser bits above bit 0 to zero.
REQ-017 SHALL derive one pipeline enable = ~out_tvalid | out_tready; all stages SHALL advance only on enable, and in_tready SHALL equal enable.
REQ-018 SHALL hold out_tdata/tlast/tuser stable while out_tvalid=1 and out_tready=0; there SHALL be no loss or duplication of beats.
REQ-019 SHALL accept a SOF beat that arrives without a preceding tlast, restarting the parity at line 0.

Reset
REQ-020 SHALL, on main_reset, clear out_tvalid, out_tdata, out_tlast and out_tuser to 0, and clear all stage valids and both parities.
REQ-021 SHALL, on main_reset, restore the latched values to their defaults: CFA map = C_CFA_MODE, gains = 0x1000, black level = 0.
REQ-022 SHALL, when reset is asserted mid-frame, discard all in-flight beats; the next output SHALL follow the next input accepted after reset.

Configuration
REQ-023 SHALL support macro INTEL_VVP_BAYER_WBAL_CLIP_CNT_EN.
- When defined: add output clip_count[31:0], the number of output pixels clipped at 2^BPS − 1 in the previous frame. It is updated at each output SOF and saturates at 0xFFFFFFFF.
- When undefined: no port and no counter logic.

Structure
REQ-024 SHALL place the following in the shared package intel_vvp_bayer_pkg:
- the CFA code enum;
- the gain width (16) and fraction width (12);
- the unity gain constant (0x1000).
REQ-025 SHALL implement the per-lane 3-stage arithmetic in the sub-module intel_vvp_bayer_wbal_lane, instantiated PIXELS_IN_PARALLEL times; the top level SHALL own the phase, register latching and handshake.

Verification
REQ-026 SHALL cover unity passthrough: gains 0x1000, black 0, input 0x155 -> output 0x155 exactly 3 cycles later.
REQ-027 SHALL cover black level and clip: black 64, r_gain_r 0x2000, R-site inputs 600 and 40 -> outputs 1023 and 0.
REQ-028 SHALL cover CFA phasing:
- setup: map 0x16, PIXELS_IN_PARALLEL=2, gains B=0x0800 G=0x1000 R=0x2000, all inputs 200, over 2 lines;
- expected line 0: 200, 100;
- expected line 1: 400, 200.
REQ-029 SHALL cover backpressure: hold out_tready low for 5 cycles mid-line -> in_tready low throughout, output held stable, and the full sequence received with no gaps or duplicates.
REQ-030 SHALL cover mid-frame register change: change r_gain_g mid-frame -> no effect until the next SOF beat, which uses the new value.
REQ-031 SHALL cover mid-line reset: pulse main_reset for 1 cycle mid-line -> out_tvalid 0 next cycle, and the next frame is phased correctly from SOF.
